// File: rtl/latch_bank_arbiter.sv
// Round-robin write controller for a bank of gated D latches: captures one request at a time and
// drives a setup / gate / hold sequence so latch data never changes while a gate is open.
module latch_bank_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned GATE_CYC = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           latch_d,
  output logic [(2**ADDR_W)-1:0]      latch_en,
  output logic                        busy
);

  localparam int unsigned NumLatch = 2 ** ADDR_W;
  localparam int unsigned PtrW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW     = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StGate,
    StHold
  } state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [PtrW-1:0]     win_q, win_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NumLatch-1:0] en_q, en_d;

  // Round-robin search: first requester at or above ptr_q, wrapping.
  logic                found;
  logic [PtrW-1:0]     pick;
  logic [31:0]         cand;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [NumLatch-1:0] addr_onehot;

  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!found && req[cand[PtrW-1:0]]) begin
        found = 1'b1;
        pick  = cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    pick_onehot       = '0;
    pick_onehot[pick] = 1'b1;
    addr_onehot         = '0;
    addr_onehot[addr_q] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
    end
  end

  // Next-state logic. Gate enables and ack are registered so the latch gates see clean edges.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ack_d   = '0;
    en_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StSetup;
          win_d   = pick;
          addr_d  = req_addr[pick*ADDR_W +: ADDR_W];
          data_d  = req_data[pick*DATA_W +: DATA_W];
          grant_d = pick_onehot;
        end
      end
      StSetup: begin
        state_d = StGate;
        cnt_d   = CntW'(GATE_CYC - 1);
        en_d    = addr_onehot;
      end
      StGate: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          ack_d   = grant_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
          en_d  = addr_onehot;
        end
      end
      StHold: begin
        state_d = StIdle;
        ptr_d   = (32'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
        grant_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    grant    = grant_q;
    ack      = ack_q;
    latch_d  = data_q;
    latch_en = en_q;
    busy     = (state_q != StIdle);
  end

  a_en_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(en_q));
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_en_only_in_gate : assert property (@(posedge clk) disable iff (rst)
    (|en_q) |-> (state_q == StGate));
  a_data_stable_when_gated : assert property (@(posedge clk) disable iff (rst)
    (|en_q) |-> $stable(data_q));

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed, table-driven bench for latch_bank_arbiter: cycle-by-cycle vectors on a GATE_CYC=1
// instance plus hand sequences for reset-mid-gate and a GATE_CYC=3 instance.
module tb_latch_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [7:0]  req_addr = '0;
  logic [3:0]  grant, ack, latch_en;
  logic [7:0]  latch_d;
  logic        busy;

  logic [3:0]  req3 = '0;
  logic [31:0] req_data3 = '0;
  logic [7:0]  req_addr3 = '0;
  logic [3:0]  grant3, ack3, latch_en3;
  logic [7:0]  latch_d3;
  logic        busy3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  latch_bank_arbiter #(.NUM_REQ(4), .DATA_W(8), .ADDR_W(2), .GATE_CYC(1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_addr(req_addr),
    .grant(grant), .ack(ack), .latch_d(latch_d), .latch_en(latch_en), .busy(busy)
  );

  latch_bank_arbiter #(.NUM_REQ(4), .DATA_W(8), .ADDR_W(2), .GATE_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_data(req_data3), .req_addr(req_addr3),
    .grant(grant3), .ack(ack3), .latch_d(latch_d3), .latch_en(latch_en3), .busy(busy3)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [7:0]  addr;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [7:0]  d;
    logic [3:0]  en;
    logic        busy;
  } vec_t;

  localparam int NumVec = 46;
  vec_t vecs [NumVec];

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [31:0] dt, logic [7:0] ad,
                              logic [3:0] g, logic [3:0] a, logic [7:0] d, logic [3:0] en,
                              logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.data = dt; v.addr = ad;
    v.grant = g; v.ack = a; v.d = d; v.en = en; v.busy = b;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Latch data must never move while any gate is open.
  logic [7:0] prev_d = '0;
  always @(negedge clk) begin
    if (!rst && latch_en != 4'b0) begin
      checks++;
      if (latch_d !== prev_d) begin
        errors++;
        $display("FAIL data_moved_while_gated: got %h, expected %h", latch_d, prev_d);
      end
    end
    prev_d = latch_d;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    // Record k: inputs driven during cycle k, outputs expected during cycle k.
    vecs[0]  = mk(0, 4'b0000, 32'h0,         8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0);
    // Single write: requester 2, data A5, addr 3.
    vecs[1]  = mk(0, 4'b0100, 32'h00A5_0000, 8'h30, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0);
    vecs[2]  = mk(0, 4'b0100, 32'h00A5_0000, 8'h30, 4'b0100, 4'b0000, 8'hA5, 4'b0000, 1);
    vecs[3]  = mk(0, 4'b0100, 32'h00A5_0000, 8'h30, 4'b0100, 4'b0000, 8'hA5, 4'b1000, 1);
    vecs[4]  = mk(0, 4'b0100, 32'h00A5_0000, 8'h30, 4'b0100, 4'b0100, 8'hA5, 4'b0000, 1);
    vecs[5]  = mk(0, 4'b0000, 32'h0,         8'h00, 4'b0000, 4'b0000, 8'hA5, 4'b0000, 0);
    // Requester 1 drops req and changes data/addr right after grant (ptr=3, wraps to 1).
    vecs[6]  = mk(0, 4'b0010, 32'h0000_3C00, 8'h04, 4'b0000, 4'b0000, 8'hA5, 4'b0000, 0);
    vecs[7]  = mk(0, 4'b0000, 32'h0000_FF00, 8'h08, 4'b0010, 4'b0000, 8'h3C, 4'b0000, 1);
    vecs[8]  = mk(0, 4'b0000, 32'h0000_FF00, 8'h08, 4'b0010, 4'b0000, 8'h3C, 4'b0010, 1);
    vecs[9]  = mk(0, 4'b0000, 32'h0000_FF00, 8'h08, 4'b0010, 4'b0010, 8'h3C, 4'b0000, 1);
    vecs[10] = mk(0, 4'b0000, 32'h0,         8'h00, 4'b0000, 4'b0000, 8'h3C, 4'b0000, 0);
    // Reset, then all four requesters held high.
    vecs[11] = mk(1, 4'b0000, 32'h0,         8'h00, 4'b0000, 4'b0000, 8'h3C, 4'b0000, 0);
    vecs[12] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0);
    vecs[13] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0001, 4'b0000, 8'h10, 4'b0000, 1);
    vecs[14] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0001, 4'b0000, 8'h10, 4'b0001, 1);
    vecs[15] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0001, 4'b0001, 8'h10, 4'b0000, 1);
    vecs[16] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0000, 4'b0000, 8'h10, 4'b0000, 0);
    vecs[17] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0010, 4'b0000, 8'h11, 4'b0000, 1);
    vecs[18] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0010, 4'b0000, 8'h11, 4'b0010, 1);
    vecs[19] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0010, 4'b0010, 8'h11, 4'b0000, 1);
    vecs[20] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0000, 4'b0000, 8'h11, 4'b0000, 0);
    vecs[21] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0100, 4'b0000, 8'h12, 4'b0000, 1);
    vecs[22] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0100, 4'b0000, 8'h12, 4'b0100, 1);
    vecs[23] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0100, 4'b0100, 8'h12, 4'b0000, 1);
    vecs[24] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0000, 4'b0000, 8'h12, 4'b0000, 0);
    vecs[25] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b1000, 4'b0000, 8'h13, 4'b0000, 1);
    vecs[26] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b1000, 4'b0000, 8'h13, 4'b1000, 1);
    vecs[27] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b1000, 4'b1000, 8'h13, 4'b0000, 1);
    vecs[28] = mk(0, 4'b1111, 32'h1312_1110, 8'hE4, 4'b0000, 4'b0000, 8'h13, 4'b0000, 0);
    vecs[29] = mk(0, 4'b0000, 32'h1312_1110, 8'hE4, 4'b0001, 4'b0000, 8'h10, 4'b0000, 1);
    vecs[30] = mk(0, 4'b0000, 32'h1312_1110, 8'hE4, 4'b0001, 4'b0000, 8'h10, 4'b0001, 1);
    vecs[31] = mk(0, 4'b0000, 32'h1312_1110, 8'hE4, 4'b0001, 4'b0001, 8'h10, 4'b0000, 1);
    vecs[32] = mk(0, 4'b0000, 32'h0,         8'h00, 4'b0000, 4'b0000, 8'h10, 4'b0000, 0);
    // req0 held one cycle past its ack while req3 pends: 0, then 3, then 0 again.
    vecs[33] = mk(0, 4'b0001, 32'hC300_005A, 8'h42, 4'b0000, 4'b0000, 8'h10, 4'b0000, 0);
    vecs[34] = mk(0, 4'b1001, 32'hC300_005A, 8'h42, 4'b0001, 4'b0000, 8'h5A, 4'b0000, 1);
    vecs[35] = mk(0, 4'b1001, 32'hC300_005A, 8'h42, 4'b0001, 4'b0000, 8'h5A, 4'b0100, 1);
    vecs[36] = mk(0, 4'b1001, 32'hC300_005A, 8'h42, 4'b0001, 4'b0001, 8'h5A, 4'b0000, 1);
    vecs[37] = mk(0, 4'b1001, 32'hC300_005A, 8'h42, 4'b0000, 4'b0000, 8'h5A, 4'b0000, 0);
    vecs[38] = mk(0, 4'b1001, 32'hC300_005A, 8'h42, 4'b1000, 4'b0000, 8'hC3, 4'b0000, 1);
    vecs[39] = mk(0, 4'b1001, 32'hC300_005A, 8'h42, 4'b1000, 4'b0000, 8'hC3, 4'b0010, 1);
    vecs[40] = mk(0, 4'b1001, 32'hC300_005A, 8'h42, 4'b1000, 4'b1000, 8'hC3, 4'b0000, 1);
    vecs[41] = mk(0, 4'b0001, 32'hC300_005A, 8'h42, 4'b0000, 4'b0000, 8'hC3, 4'b0000, 0);
    vecs[42] = mk(0, 4'b0000, 32'hC300_005A, 8'h42, 4'b0001, 4'b0000, 8'h5A, 4'b0000, 1);
    vecs[43] = mk(0, 4'b0000, 32'hC300_005A, 8'h42, 4'b0001, 4'b0000, 8'h5A, 4'b0100, 1);
    vecs[44] = mk(0, 4'b0000, 32'hC300_005A, 8'h42, 4'b0001, 4'b0001, 8'h5A, 4'b0000, 1);
    vecs[45] = mk(0, 4'b0000, 32'h0,         8'h00, 4'b0000, 4'b0000, 8'h5A, 4'b0000, 0);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      check("grant", i, 32'(grant), 32'(vecs[i].grant));
      check("ack", i, 32'(ack), 32'(vecs[i].ack));
      check("latch_d", i, 32'(latch_d), 32'(vecs[i].d));
      check("latch_en", i, 32'(latch_en), 32'(vecs[i].en));
      check("busy", i, 32'(busy), 32'(vecs[i].busy));
      rst      = vecs[i].rst;
      req      = vecs[i].req;
      req_data = vecs[i].data;
      req_addr = vecs[i].addr;
    end

    // Reset asserted mid-GATE: outputs clear at once and the aborted write never acks.
    @(negedge clk);
    req      = 4'b0100;
    req_data = 32'h0077_0000;
    req_addr = 8'h00;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (latch_en != 4'b0) seen = 1'b1;
    end
    check("gate_reached", 0, 32'(seen), 32'd1);
    rst = 1'b1;
    req = 4'b0000;
    #1;
    check("rst_latch_en", 0, 32'(latch_en), 32'h0);
    check("rst_grant", 0, 32'(grant), 32'h0);
    check("rst_busy", 0, 32'(busy), 32'h0);
    check("rst_ack", 0, 32'(ack), 32'h0);
    check("rst_latch_d", 0, 32'(latch_d), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("post_rst_ack", n, 32'(ack), 32'h0);
      check("post_rst_busy", n, 32'(busy), 32'h0);
    end
    req      = 4'b1111;
    req_data = 32'h1312_1110;
    req_addr = 8'hE4;
    @(negedge clk);
    check("post_rst_ptr_grant", 0, 32'(grant), 32'b0001);
    req = 4'b0000;
    repeat (4) @(negedge clk);

    // GATE_CYC=3 instance: gate open cycles 2..4, ack in cycle 5, idle in cycle 6.
    req3      = 4'b0001;
    req_data3 = 32'h0000_0099;
    req_addr3 = 8'h02;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      req3 = 4'b0000;
      check("g3_latch_en", k, 32'(latch_en3), (k >= 2 && k <= 4) ? 32'b0100 : 32'h0);
      check("g3_ack", k, 32'(ack3), (k == 5) ? 32'b0001 : 32'h0);
      check("g3_busy", k, 32'(busy3), (k <= 5) ? 32'd1 : 32'd0);
      check("g3_latch_d", k, 32'(latch_d3), 32'h99);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
